// File: rtl/pipe_adder_if.sv
// pipe_adder_if: operand/result handshake bundle for pipe_adder.
// master = producer of operands / consumer of results, slave = the adder.
// The ovf signal exists only when PIPE_ADDER_OVF_EN is defined.
interface pipe_adder_if #(
  parameter int WIDTH = 16,
  parameter int OFF_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [OFF_W-1:0] b;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] o;
  logic             carry_out;
`ifdef PIPE_ADDER_OVF_EN
  logic             ovf;

  modport master (output in_valid, a, b, op_sub, out_ready,
                  input  in_ready, out_valid, o, carry_out, ovf);
  modport slave  (input  in_valid, a, b, op_sub, out_ready,
                  output in_ready, out_valid, o, carry_out, ovf);
`else
  modport master (output in_valid, a, b, op_sub, out_ready,
                  input  in_ready, out_valid, o, carry_out);
  modport slave  (input  in_valid, a, b, op_sub, out_ready,
                  output in_ready, out_valid, o, carry_out);
`endif
endinterface

// File: rtl/pipe_adder.sv
// pipe_adder: carry-chained adder/subtractor split into STAGES chunks of
// WIDTH/STAGES bits. Stage k adds chunk k using the carry registered by
// stage k-1; the last stage register is the output register.
// Optional signed-overflow flag enabled by defining PIPE_ADDER_OVF_EN.
module pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int OFF_W  = 16,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  pipe_adder_if.slave  bus
);
  localparam int C    = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;
  // operand copies are only needed by stages that still have chunks to add
  localparam int OPS  = (STAGES > 1) ? STAGES - 1 : 1;

  if (WIDTH < 4 || WIDTH > 64 || OFF_W < 1 || OFF_W > WIDTH ||
      STAGES < 1 || STAGES > 4 || (WIDTH % STAGES) != 0) begin : gParamErr
    $error("pipe_adder: illegal WIDTH/OFF_W/STAGES combination");
  end

  logic                en;
  logic [STAGES-1:0]   vldPipe;
  logic [STAGES-1:0]   rCy;
  logic [WIDTH-1:0]    rRes [STAGES];
  logic [WIDTH-1:0]    rA   [OPS];
  logic [WIDTH-1:0]    rB   [OPS];
  logic [OPS-1:0]      rSub;

  logic                curVld [STAGES];
  logic                curSub [STAGES];
  logic                curCy  [STAGES];
  logic [WIDTH-1:0]    curA   [STAGES];
  logic [WIDTH-1:0]    curB   [STAGES];
  logic [WIDTH-1:0]    curRes [STAGES];
  logic [WIDTH-1:0]    nxtRes [STAGES];
  logic [C:0]          sum    [STAGES];
  logic signed [OFF_W-1:0] bSgn;

  assign en           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;
  assign bSgn         = bus.b;

  for (genvar k = 0; k < STAGES; k++) begin : gStage
    if (k == 0) begin : gIn
      assign curVld[k] = bus.in_valid;
      assign curA[k]   = bus.a;
      assign curB[k]   = WIDTH'(bSgn);
      assign curSub[k] = bus.op_sub;
      assign curRes[k] = '0;
      assign curCy[k]  = bus.op_sub;
    end else begin : gChain
      assign curVld[k] = vldPipe[k-1];
      assign curA[k]   = rA[k-1];
      assign curB[k]   = rB[k-1];
      assign curSub[k] = rSub[k-1];
      assign curRes[k] = rRes[k-1];
      assign curCy[k]  = rCy[k-1];
    end
    // chunk k of a + (b or ~b) + incoming carry
    assign sum[k] = {1'b0, curA[k][k*C +: C]}
                  + {1'b0, curB[k][k*C +: C] ^ {C{curSub[k]}}}
                  + (C+1)'(curCy[k]);
    assign nxtRes[k] = curRes[k] | (WIDTH'(sum[k][C-1:0]) << (k*C));
  end

  // stage registers: all advance together on en, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vldPipe <= '0;
      rCy     <= '0;
      rSub    <= '0;
      for (int k = 0; k < STAGES; k++) rRes[k] <= '0;
      for (int k = 0; k < OPS; k++) begin
        rA[k] <= '0;
        rB[k] <= '0;
      end
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        vldPipe[k] <= curVld[k];
        rRes[k]    <= nxtRes[k];
        rCy[k]     <= sum[k][C];
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        rA[k]   <= curA[k];
        rB[k]   <= curB[k];
        rSub[k] <= curSub[k];
      end
    end
  end

  assign bus.out_valid = vldPipe[LAST];
  assign bus.o         = rRes[LAST];
  assign bus.carry_out = rCy[LAST];

`ifdef PIPE_ADDER_OVF_EN
  logic rOvf, ovfNxt, aMsb, bMsb, rMsb;
  assign aMsb   = curA[LAST][WIDTH-1];
  assign bMsb   = curB[LAST][WIDTH-1] ^ curSub[LAST];
  assign rMsb   = sum[LAST][C-1];
  assign ovfNxt = (aMsb == bMsb) && (rMsb != aMsb);

  // signed overflow flag, registered alongside the final result chunk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rOvf <= 1'b0;
    else if (en) rOvf <= ovfNxt;
  end
  assign bus.ovf = rOvf;
`endif
endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed vectors plus random traffic against a
// queue-based arithmetic reference model.
module tb_pipe_adder;
  localparam int W  = 16;
  localparam int OW = 8;
  localparam int ST = 2;

  logic clk = 0;
  logic rst_n;
  int   nChk = 0, nErr = 0, nIn = 0, nOut = 0;
  bit   monEn = 0;
  logic [W+1:0] expQ [$];

  pipe_adder_if #(.WIDTH(W), .OFF_W(OW)) bus ();
  pipe_adder #(.WIDTH(W), .OFF_W(OW), .STAGES(ST)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChk++;
    if (obs !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {ovf, carry, o} from plain integer arithmetic
  function automatic logic [W+1:0] model(input logic [W-1:0] av,
                                         input logic [OW-1:0] bv, input logic sub);
    longint mask, ua, ub, sb, sa, r, sr;
    logic signed [OW-1:0] bs;
    logic signed [W-1:0]  as_;
    logic cy, ov;
    mask = (longint'(1) << W) - 1;
    bs = bv; as_ = av;
    sb = longint'(bs); sa = longint'(as_);
    ua = longint'(av); ub = sb & mask;
    if (sub) begin r = ua - ub; cy = (ua >= ub); sr = sa - sb; end
    else     begin r = ua + ub; cy = (r > mask); sr = sa + sb; end
    ov = (sr > (mask >> 1)) || (sr < -((mask >> 1) + 1));
    return {ov, cy, r[W-1:0]};
  endfunction

  // scoreboard: capture accepts, check every valid output cycle vs queue head
  always @(negedge clk) begin
    if (monEn && rst_n) begin
      if (bus.in_valid && bus.in_ready) begin
        expQ.push_back(model(bus.a, bus.b, bus.op_sub));
        nIn++;
      end
      if (bus.out_valid) begin
        if (expQ.size() == 0) chk("spurious_out", 1, 0);
        else begin
          chk("sb_o",  bus.o,         expQ[0][W-1:0]);
          chk("sb_cy", bus.carry_out, expQ[0][W]);
`ifdef PIPE_ADDER_OVF_EN
          chk("sb_ovf", bus.ovf,      expQ[0][W+1]);
`endif
          if (bus.out_ready) begin
            void'(expQ.pop_front());
            nOut++;
          end
        end
      end
    end
  end

  // called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic drive(input logic [W-1:0] av, input logic [OW-1:0] bv, input logic sub);
    int n = 0;
    bus.in_valid = 1; bus.a = av; bus.b = bv; bus.op_sub = sub;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic vec(input logic [W-1:0] av, input logic [OW-1:0] bv, input logic sub,
                     input logic [W-1:0] eo, input logic ec, input logic ev);
    int n = 0;
    drive(av, bv, sub);
    bus.in_valid = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("vec_valid", bus.out_valid, 1);
    chk("vec_o", bus.o, eo);
    chk("vec_cy", bus.carry_out, ec);
`ifdef PIPE_ADDER_OVF_EN
    chk("vec_ovf", bus.ovf, ev);
`else
    if (ev === 1'bx) chk("vec_ev", ev, 0);
`endif
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (expQ.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(tag, expQ.size(), 0);
    chk({tag, "_cnt"}, nOut, nIn);
  endtask

  initial begin
    rst_n = 0;
    bus.in_valid = 0; bus.a = '0; bus.b = '0; bus.op_sub = 0; bus.out_ready = 1;
    #12;
    chk("rst_ovld", bus.out_valid, 0);
    chk("rst_o", bus.o, 0);
    chk("rst_cy", bus.carry_out, 0);
    chk("rst_irdy", bus.in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1; monEn = 1;
    @(posedge clk); #1;

    // latency: accept at edge N, result after edge N+ST-1, exactly one beat
    bus.a = 16'h0100; bus.b = 8'h04; bus.op_sub = 0; bus.in_valid = 1;
    @(posedge clk); #1;
    bus.in_valid = 0;
    for (int i = 1; i < ST; i++) begin
      @(negedge clk); chk("lat_early", bus.out_valid, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("lat_valid", bus.out_valid, 1);
    chk("lat_o", bus.o, 16'h0104);
    chk("lat_cy", bus.carry_out, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("lat_one", bus.out_valid, 0);
    @(posedge clk); #1;

    // sign extension, borrow, cross-chunk carry, overflow corners
    vec(16'h0010, 8'hF0, 0, 16'h0000, 1, 0);
    vec(16'h0005, 8'h06, 1, 16'hFFFF, 0, 0);
    vec(16'h00FF, 8'h01, 0, 16'h0100, 0, 0);
    vec(16'h7FFF, 8'h01, 0, 16'h8000, 0, 1);
    vec(16'h8000, 8'h01, 1, 16'h7FFF, 1, 1);
    vec(16'hFFFF, 8'h01, 0, 16'h0000, 1, 0);

    // stall: 3 back-to-back beats with out_ready low for 4 cycles
    bus.out_ready = 0;
    fork
      begin
        for (int i = 0; i < 3; i++) drive(W'($urandom), OW'($urandom), 1'($urandom));
        bus.in_valid = 0;
      end
      begin
        repeat (ST) @(posedge clk);
        @(negedge clk);
        chk("stall_irdy", bus.in_ready, 0);
        chk("stall_ovld", bus.out_valid, 1);
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1;
      end
    join
    drain("stall_drain");

    // reset with 2 beats in flight
    @(posedge clk); #1;
    bus.out_ready = 0;
    drive(16'h1111, 8'h22, 0);
    drive(16'h3333, 8'h44, 1);
    bus.in_valid = 0;
    #3;
    rst_n = 0; monEn = 0;
    nIn -= expQ.size();
    expQ.delete();
    #1;
    chk("mrst_ovld", bus.out_valid, 0);
    chk("mrst_o", bus.o, 0);
    chk("mrst_irdy", bus.in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1; monEn = 1; bus.out_ready = 1;
    repeat (4) begin
      @(negedge clk); chk("mrst_stale", bus.out_valid, 0);
    end
    @(posedge clk); #1;
    vec(16'h1234, 8'h11, 0, 16'h1245, 0, 0);

    // random traffic with random backpressure and bubbles
    repeat (400) begin
      @(posedge clk); #1;
      bus.in_valid  = ($urandom % 4) != 0;
      bus.a         = W'($urandom);
      bus.b         = OW'($urandom);
      bus.op_sub    = 1'($urandom);
      bus.out_ready = ($urandom % 3) != 0;
    end
    @(posedge clk); #1;
    bus.in_valid = 0; bus.out_ready = 1;
    drain("rand_drain");

    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end
endmodule
